// File: rtl/mem_stage_ls_if.sv
// Execute/write-back/data-SRAM/forwarding signal bundle for the memory-access stage.
// The stage itself connects through the slave modport.
interface mem_stage_ls_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32,
  parameter int unsigned RA_W = 5
);
  localparam int unsigned EXE_BUS_W = 6 + RA_W + XLEN + PC_W;
  localparam int unsigned WB_BUS_W  = 1 + RA_W + XLEN + PC_W;

  logic                 exe_to_mem_valid;
  logic [EXE_BUS_W-1:0] exe_to_mem_bus;
  logic                 mem_allowin;
  logic                 wb_allowin;
  logic                 mem_to_wb_valid;
  logic [WB_BUS_W-1:0]  mem_to_wb_bus;
  logic                 data_sram_data_ok;
  logic [XLEN-1:0]      data_sram_rdata;
  logic                 mem_flush;
  logic                 fwd_valid;
  logic [RA_W-1:0]      fwd_dest;
  logic [XLEN-1:0]      fwd_result;
  logic                 fwd_blocked;

  modport master (
    output exe_to_mem_valid, exe_to_mem_bus, wb_allowin,
           data_sram_data_ok, data_sram_rdata, mem_flush,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
           fwd_valid, fwd_dest, fwd_result, fwd_blocked
  );

  modport slave (
    input  exe_to_mem_valid, exe_to_mem_bus, wb_allowin,
           data_sram_data_ok, data_sram_rdata, mem_flush,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
           fwd_valid, fwd_dest, fwd_result, fwd_blocked
  );
endinterface

// File: rtl/mem_stage_ls.sv
// Memory-access pipeline stage: waits for the data-SRAM response, extends loads,
// buffers load data across write-back stalls and drops responses of flushed loads.
module mem_stage_ls #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned CANCEL_W = 2
) (
  input logic          clk,
  input logic          resetn,
  mem_stage_ls_if.slave io
);
  localparam int unsigned IN_W  = 6 + RA_W + XLEN + PC_W;
  localparam int unsigned OFF_W = $clog2(XLEN / 8);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic                mem_valid_q, mem_valid_d;
  logic                buf_valid_q, buf_valid_d;
  logic [XLEN-1:0]     buf_data_q, buf_data_d;
  logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;
  logic [IN_W-1:0]     bus_q, bus_d;

  logic            req, ld_en, gr_we;
  logic [2:0]      ld_type;
  logic [RA_W-1:0] dest;
  logic [XLEN-1:0] alu_result;
  logic [PC_W-1:0] pc;

  assign {req, ld_en, ld_type, gr_we, dest, alu_result, pc} = bus_q;

  logic       data_use_c, discard_c, ready_go_c, allowin_c, leave_c, accept_c;
  logic       cancel_inc_c;
  logic [1:0] state_c;

  // A response is ours only once every owed response of a flushed load has drained.
  assign data_use_c = io.data_sram_data_ok && (cancel_cnt_q == '0);
  assign discard_c  = io.data_sram_data_ok && (cancel_cnt_q != '0);
  assign ready_go_c = !req || buf_valid_q || data_use_c;

  always_comb begin
    state_c = S_EMPTY;
    if (mem_valid_q) state_c = ready_go_c ? S_READY : S_WAIT;
  end

  assign allowin_c    = (state_c == S_EMPTY) || ((state_c == S_READY) && io.wb_allowin);
  assign leave_c      = (state_c == S_READY) && io.wb_allowin;
  assign accept_c     = io.exe_to_mem_valid && allowin_c && !io.mem_flush;
  assign cancel_inc_c = io.mem_flush && (state_c == S_WAIT) && !buf_valid_q;

  logic [XLEN-1:0] raw_data, ext_data, final_result;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;

  // Lane select and sign/zero extension; unknown encodings fall back to word.
  always_comb begin
    raw_data = buf_valid_q ? buf_data_q : io.data_sram_rdata;
    lane_b   = 8'(raw_data >> {alu_result[OFF_W-1:0], 3'b000});
    lane_h   = 16'(raw_data >> {alu_result[OFF_W-1:0], 3'b000});
    case (ld_type)
      3'b001:  ext_data = XLEN'($signed(lane_b));
      3'b101:  ext_data = XLEN'(lane_b);
      3'b010:  ext_data = XLEN'($signed(lane_h));
      3'b110:  ext_data = XLEN'(lane_h);
      3'b011:  ext_data = (XLEN == 64) ? raw_data : XLEN'($signed(raw_data[31:0]));
      default: ext_data = XLEN'($signed(raw_data[31:0]));
    endcase
    final_result = ld_en ? ext_data : alu_result;
  end

  always_comb begin
    mem_valid_d  = mem_valid_q;
    buf_valid_d  = buf_valid_q;
    buf_data_d   = buf_data_q;
    cancel_cnt_d = cancel_cnt_q;
    bus_d        = bus_q;
    if (io.mem_flush) begin
      mem_valid_d = 1'b0;
      buf_valid_d = 1'b0;
    end else begin
      if (allowin_c) mem_valid_d = io.exe_to_mem_valid;
      if (leave_c) begin
        buf_valid_d = 1'b0;
      end else if (mem_valid_q && req && !buf_valid_q && data_use_c) begin
        buf_valid_d = 1'b1;
        buf_data_d  = io.data_sram_rdata;
      end
    end
    if (accept_c) bus_d = io.exe_to_mem_bus;
    case ({cancel_inc_c, discard_c})
      2'b10:   cancel_cnt_d = cancel_cnt_q + CANCEL_W'(1);
      2'b01:   cancel_cnt_d = cancel_cnt_q - CANCEL_W'(1);
      default: cancel_cnt_d = cancel_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q  <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_data_q   <= '0;
      cancel_cnt_q <= '0;
      bus_q        <= '0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      buf_valid_q  <= buf_valid_d;
      buf_data_q   <= buf_data_d;
      cancel_cnt_q <= cancel_cnt_d;
      bus_q        <= bus_d;
    end
  end

  assign io.mem_allowin     = allowin_c;
  assign io.mem_to_wb_valid = mem_valid_q && ready_go_c && !io.mem_flush;
  assign io.mem_to_wb_bus   = {gr_we, dest, final_result, pc};
  assign io.fwd_valid       = mem_valid_q && gr_we && (dest != '0);
  assign io.fwd_dest        = dest;
  assign io.fwd_result      = final_result;
  assign io.fwd_blocked     = mem_valid_q && gr_we && (dest != '0) && ld_en && !ready_go_c;

  a_cancel_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(cancel_inc_c && !discard_c && (cancel_cnt_q == '1)));

  a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (!resetn)
    !(io.data_sram_data_ok && !mem_valid_q && (cancel_cnt_q == '0)));
endmodule

// File: tb/tb_mem_stage_ls.sv
// Scoreboard bench for mem_stage_ls: expected write-back payloads are queued at issue
// and compared whenever the stage hands a result to write-back.
module tb_mem_stage_ls;
  localparam int unsigned XLEN = 32;
  localparam int unsigned PC_W = 32;
  localparam int unsigned RA_W = 5;
  localparam int unsigned EXE_W = 6 + RA_W + XLEN + PC_W;
  localparam int unsigned WB_W  = 1 + RA_W + XLEN + PC_W;

  typedef struct packed {
    logic [RA_W-1:0] dest;
    logic [XLEN-1:0] result;
    logic [PC_W-1:0] pc;
  } exp_t;

  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [PC_W-1:0] pc_n = 32'h1c00_0000;

  mem_stage_ls_if #(.XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W)) ifc ();

  mem_stage_ls #(.XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W), .CANCEL_W(2)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [EXE_W-1:0] mk(input logic req, input logic ld_en,
                                          input logic [2:0] t, input logic [RA_W-1:0] d,
                                          input logic [XLEN-1:0] alu, input logic [PC_W-1:0] pc);
    return {req, ld_en, t, 1'b1, d, alu, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until the stage accepts it.
  task automatic issue(input logic req, input logic ld_en, input logic [2:0] t,
                       input logic [RA_W-1:0] d, input logic [XLEN-1:0] alu);
    bit ok;
    ok = 1'b0;
    pc_n = pc_n + 32'd4;
    ifc.exe_to_mem_valid = 1'b1;
    ifc.exe_to_mem_bus   = mk(req, ld_en, t, d, alu, pc_n);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (ifc.mem_allowin && !ifc.mem_flush) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("issue_timeout", 64'd0, 64'd1);
    tick();
    ifc.exe_to_mem_valid = 1'b0;
    #1;
  endtask

  task automatic push(input logic [RA_W-1:0] d, input logic [XLEN-1:0] r);
    exp_t e;
    e.dest = d;
    e.result = r;
    e.pc = pc_n;
    exp_q.push_back(e);
  endtask

  task automatic sized_load(input logic [2:0] t, input logic [XLEN-1:0] alu,
                            input logic [XLEN-1:0] rd, input logic [XLEN-1:0] exp);
    issue(1'b1, 1'b1, t, 5'd5, alu);
    push(5'd5, exp);
    check("load_blocked_before_data", 64'(ifc.fwd_blocked), 64'd1);
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = rd;
    ifc.wb_allowin        = 1'b1;
    #1;
    check("load_fwd_result", 64'(ifc.fwd_result), 64'(exp));
    tick();
    ifc.data_sram_data_ok = 1'b0;
    ifc.data_sram_rdata   = '0;
  endtask

  // Compare every write-back handoff against the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn && ifc.mem_to_wb_valid && ifc.wb_allowin) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 64'(ifc.mem_to_wb_bus[PC_W +: XLEN]), 64'hdead);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_result", 64'(ifc.mem_to_wb_bus[PC_W +: XLEN]), 64'(mon_e.result));
        check("wb_dest", 64'(ifc.mem_to_wb_bus[PC_W+XLEN +: RA_W]), 64'(mon_e.dest));
        check("wb_pc", 64'(ifc.mem_to_wb_bus[PC_W-1:0]), 64'(mon_e.pc));
        check("wb_gr_we", 64'(ifc.mem_to_wb_bus[WB_W-1]), 64'd1);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    ifc.exe_to_mem_valid  = 1'b0;
    ifc.exe_to_mem_bus    = '0;
    ifc.wb_allowin        = 1'b1;
    ifc.data_sram_data_ok = 1'b0;
    ifc.data_sram_rdata   = '0;
    ifc.mem_flush         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_allowin", 64'(ifc.mem_allowin), 64'd1);
    check("rst_wb_valid", 64'(ifc.mem_to_wb_valid), 64'd0);
    check("rst_fwd_valid", 64'(ifc.fwd_valid), 64'd0);
    check("rst_fwd_dest", 64'(ifc.fwd_dest), 64'd0);
    check("rst_fwd_result", 64'(ifc.fwd_result), 64'd0);
    check("rst_fwd_blocked", 64'(ifc.fwd_blocked), 64'd0);
    resetn = 1'b1;
    tick();

    sized_load(3'b001, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80);
    sized_load(3'b101, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080);
    sized_load(3'b010, 32'h0000_2002, 32'h8001_1234, 32'hFFFF_8001);
    sized_load(3'b110, 32'h0000_2002, 32'h8001_1234, 32'h0000_8001);
    sized_load(3'b000, 32'h0000_3000, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Load waiting for data, then held from the buffer while write-back stalls.
    ifc.wb_allowin = 1'b0;
    issue(1'b1, 1'b1, 3'b000, 5'd7, 32'h0000_4000);
    push(5'd7, 32'h1234_5678);
    for (int i = 0; i < 2; i++) begin
      check("stall_blocked_wait", 64'(ifc.fwd_blocked), 64'd1);
      check("stall_wb_valid_wait", 64'(ifc.mem_to_wb_valid), 64'd0);
      tick();
    end
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'h1234_5678;
    #1;
    check("stall_wb_valid_dataok", 64'(ifc.mem_to_wb_valid), 64'd1);
    check("stall_blocked_dataok", 64'(ifc.fwd_blocked), 64'd0);
    check("stall_allowin_dataok", 64'(ifc.mem_allowin), 64'd0);
    tick();
    ifc.data_sram_data_ok = 1'b0;
    ifc.data_sram_rdata   = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_buf_result", 64'(ifc.fwd_result), 64'h1234_5678);
      check("stall_buf_wb_valid", 64'(ifc.mem_to_wb_valid), 64'd1);
      tick();
    end
    ifc.wb_allowin = 1'b1;
    tick();
    check("stall_drained", 64'(ifc.mem_to_wb_valid), 64'd0);

    // Flush a waiting load; its late response must be swallowed.
    issue(1'b1, 1'b1, 3'b000, 5'd8, 32'h0000_5000);
    ifc.mem_flush        = 1'b1;
    ifc.exe_to_mem_valid = 1'b1;
    ifc.exe_to_mem_bus   = mk(1'b0, 1'b0, 3'b000, 5'd3, 32'h0000_0333, 32'h0);
    #1;
    check("flush_wb_valid", 64'(ifc.mem_to_wb_valid), 64'd0);
    tick();
    ifc.mem_flush        = 1'b0;
    ifc.exe_to_mem_valid = 1'b0;
    #1;
    check("flush_stage_empty", 64'(ifc.fwd_valid), 64'd0);
    check("flush_allowin", 64'(ifc.mem_allowin), 64'd1);
    issue(1'b1, 1'b1, 3'b000, 5'd9, 32'h0000_6000);
    push(5'd9, 32'h0000_0042);
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    check("discard_wb_valid", 64'(ifc.mem_to_wb_valid), 64'd0);
    check("discard_blocked", 64'(ifc.fwd_blocked), 64'd1);
    tick();
    ifc.data_sram_data_ok = 1'b0;
    tick();
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'h0000_0042;
    #1;
    check("discard_then_result", 64'(ifc.fwd_result), 64'h0000_0042);
    tick();
    ifc.data_sram_data_ok = 1'b0;

    // Flush coinciding with the response: nothing is owed afterwards.
    issue(1'b1, 1'b1, 3'b000, 5'd10, 32'h0000_7000);
    ifc.mem_flush         = 1'b1;
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'h0000_0055;
    #1;
    check("flush_dataok_wb_valid", 64'(ifc.mem_to_wb_valid), 64'd0);
    tick();
    ifc.mem_flush         = 1'b0;
    ifc.data_sram_data_ok = 1'b0;

    for (int i = 0; i < 4; i++) begin
      logic [RA_W-1:0] d;
      logic [XLEN-1:0] a;
      d = (i == 3) ? 5'd0 : 5'(i + 11);
      a = 32'h0000_0100 + 32'(i * 17);
      pc_n = pc_n + 32'd4;
      ifc.exe_to_mem_valid = 1'b1;
      ifc.exe_to_mem_bus   = mk(1'b0, 1'b0, 3'b000, d, a, pc_n);
      push(d, a);
      tick();
      check("alu_fwd_valid", 64'(ifc.fwd_valid), (d != 0) ? 64'd1 : 64'd0);
      check("alu_fwd_dest", 64'(ifc.fwd_dest), 64'(d));
      check("alu_fwd_result", 64'(ifc.fwd_result), 64'(a));
      check("alu_allowin", 64'(ifc.mem_allowin), 64'd1);
    end
    ifc.exe_to_mem_valid = 1'b0;

    issue(1'b1, 1'b1, 3'b000, 5'd20, 32'h0000_8000);
    push(5'd20, 32'h0000_0077);
    tick();
    ifc.data_sram_data_ok = 1'b1;
    ifc.data_sram_rdata   = 32'h0000_0077;
    tick();
    ifc.data_sram_data_ok = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while a load is waiting.
    issue(1'b1, 1'b1, 3'b000, 5'd21, 32'h0000_9000);
    check("pre_reset_blocked", 64'(ifc.fwd_blocked), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_allowin", 64'(ifc.mem_allowin), 64'd1);
    check("async_rst_wb_valid", 64'(ifc.mem_to_wb_valid), 64'd0);
    check("async_rst_fwd_valid", 64'(ifc.fwd_valid), 64'd0);
    check("async_rst_fwd_blocked", 64'(ifc.fwd_blocked), 64'd0);
    check("async_rst_fwd_dest", 64'(ifc.fwd_dest), 64'd0);
    check("async_rst_fwd_result", 64'(ifc.fwd_result), 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("post_rst_allowin", 64'(ifc.mem_allowin), 64'd1);
    check("post_rst_fwd_valid", 64'(ifc.fwd_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
